// File: rtl/evt_dispatcher_pkg.sv
// Shared constants, event type and arbiter helper for the event dispatcher.
package evt_dispatcher_pkg;

  localparam int NUM_CH_DEF       = 4;
  localparam int PACKET_BITS_DEF  = 72;
  localparam int KEY_LSB_DEF      = 8;
  localparam int EVT_BITS_DEF     = 32;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int EVT_CNT_BITS_DEF = 10;
  localparam int TCK_CNT_BITS_DEF = 32;

  typedef logic [EVT_BITS_DEF-1:0] evt_t;

  // Channel index reached by stepping offs places past base, modulo n.
  function automatic int rr_index(input int base, input int offs, input int n);
    int s;
    s = base + offs;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/evt_dispatcher_mc_fifo.sv
// Synchronous event FIFO; read data is the head word, consumed on rd_en.
module evt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  // Storage carries no reset so it maps onto RAM; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/evt_dispatcher_mc.sv
// Round-robin packet intake, shared event FIFO and AXI-Stream framing with size/tick close.
module evt_dispatcher_mc
  import evt_dispatcher_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int PACKET_BITS  = PACKET_BITS_DEF,
  parameter int KEY_LSB      = KEY_LSB_DEF,
  parameter int EVT_BITS     = EVT_BITS_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int EVT_CNT_BITS = EVT_CNT_BITS_DEF,
  parameter int TCK_CNT_BITS = TCK_CNT_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH*PACKET_BITS-1:0] pkt_data_in,
  input  logic [NUM_CH-1:0]             pkt_vld_in,
  output logic [NUM_CH-1:0]             pkt_rdy_out,
  input  logic [EVT_CNT_BITS-1:0]       output_size_in,
  input  logic [TCK_CNT_BITS-1:0]       output_tick_in,
  input  logic                          drop_mode_in,
  output logic [EVT_BITS-1:0]           evt_data_out,
  output logic [EVT_BITS/8-1:0]         evt_keep_out,
  output logic                          evt_last_out,
  output logic                          evt_vld_out,
  input  logic                          evt_rdy_in,
  output logic [NUM_CH-1:0]             drp_cnt_out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [TCK_CNT_BITS-1:0] TCK_MAX = '1;

  logic [CH_W-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]         rr_cand;
  logic [CH_W-1:0]         grant_idx;
  logic [NUM_CH-1:0]       grant;
  logic                    grant_vld;
  logic [EVT_BITS-1:0]     chan_key [NUM_CH];
  logic                    ready_en_reg;
  logic                    accept_ok, pkt_hs, fifo_wr, pkt_drop;
  logic [NUM_CH-1:0]       drp_reg;

  logic                    fifo_full, fifo_empty;
  logic [AW:0]             fifo_count;
  logic [EVT_BITS-1:0]     fifo_rd_data;

  logic                    hold_vld_reg, hold_load;
  logic [EVT_BITS-1:0]     hold_data_reg;
  logic                    pres_reg, pres_last_reg;
  logic                    frame_open_reg, first_load, out_hs, last_hs;
  logic [EVT_CNT_BITS-1:0] frame_cnt_reg, size_m1;
  logic [TCK_CNT_BITS-1:0] tick_reg;
  logic                    size_hit, tick_hit, present_ok, last_comb;
  logic                    unused_ok;

  // Lowest offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    rr_cand   = '0;
    grant_idx = rr_ptr_reg;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_cand = CH_W'(rr_index(int'(rr_ptr_reg), k, NUM_CH));
      if (pkt_vld_in[rr_cand]) begin
        grant_idx = rr_cand;
        grant_vld = 1'b1;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  assign accept_ok = ready_en_reg && (!fifo_full || drop_mode_in);
  assign pkt_hs    = grant_vld && accept_ok;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign chan_key[gi]    = pkt_data_in[gi*PACKET_BITS + KEY_LSB +: EVT_BITS];
      assign pkt_rdy_out[gi] = grant[gi] && accept_ok;
      assign drp_cnt_out[gi] = drp_reg[gi];
    end
  endgenerate

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (pkt_hs)
      rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
  end

  // A full FIFO still takes a word when the hold register drains it this cycle.
  assign hold_load = !fifo_empty && (!hold_vld_reg || out_hs);
  assign fifo_wr   = pkt_hs && (!fifo_full || hold_load);
  assign pkt_drop  = pkt_hs && !fifo_wr;

  evt_fifo #(
    .WIDTH (EVT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (chan_key[grant_idx]),
    .rd_en   (hold_load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // >= rather than == so a size lowered mid-frame closes the frame at once.
  assign size_m1    = (output_size_in == '0) ? '0 : output_size_in - EVT_CNT_BITS'(1);
  assign size_hit   = (frame_cnt_reg >= size_m1);
  assign tick_hit   = (output_tick_in != '0) && (tick_reg >= output_tick_in);
  assign present_ok = !fifo_empty || size_hit || tick_hit;
  assign last_comb  = size_hit || tick_hit;

  // Once presented, the word and its last flag are frozen until accepted.
  assign evt_vld_out  = hold_vld_reg && (pres_reg || present_ok);
  assign evt_last_out = evt_vld_out && (pres_reg ? pres_last_reg : last_comb);
  assign evt_data_out = hold_data_reg;
  assign evt_keep_out = {(EVT_BITS/8){evt_vld_out}};

  assign out_hs     = evt_vld_out && evt_rdy_in;
  assign last_hs    = out_hs && evt_last_out;
  assign first_load = hold_load && (!frame_open_reg || last_hs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_reg   <= 1'b0;
      rr_ptr_reg     <= '0;
      drp_reg        <= '0;
      hold_vld_reg   <= 1'b0;
      hold_data_reg  <= '0;
      pres_reg       <= 1'b0;
      pres_last_reg  <= 1'b0;
      frame_open_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      tick_reg       <= '0;
    end else begin
      ready_en_reg  <= 1'b1;
      rr_ptr_reg    <= rr_ptr_next;
      drp_reg       <= pkt_drop ? grant : '0;
      pres_reg      <= evt_vld_out && !evt_rdy_in;
      pres_last_reg <= evt_last_out;

      if (hold_load) begin
        hold_vld_reg  <= 1'b1;
        hold_data_reg <= fifo_rd_data;
      end else if (out_hs) begin
        hold_vld_reg  <= 1'b0;
      end

      if (out_hs)
        frame_cnt_reg <= evt_last_out ? '0 : frame_cnt_reg + EVT_CNT_BITS'(1);

      if (first_load)   frame_open_reg <= 1'b1;
      else if (last_hs) frame_open_reg <= 1'b0;

      if (first_load)
        tick_reg <= '0;
      else if (frame_open_reg && !last_hs && tick_reg != TCK_MAX)
        tick_reg <= tick_reg + TCK_CNT_BITS'(1);
    end
  end

  assign unused_ok = ^{pkt_data_in, fifo_count};

endmodule
